// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding (MEM / WB / retired-WB sources) and load-use stall sequencing.
// state | meaning
// IDLE  | no extra bubbles owed; stall/flush follow the live load-use hazard
// HOLD  | inserting the remaining bubbles of a multi-bubble load-use hazard
module fwd_hazard_unit #(
    parameter int XLEN             = 32,
    parameter int RA_W             = 5,
    parameter int LOAD_BUBBLES     = 1,
    parameter int RF_WRITE_THROUGH = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [RA_W-1:0] rs1_D,
    input  logic [RA_W-1:0] rs2_D,
    input  logic [RA_W-1:0] rs1_E,
    input  logic [RA_W-1:0] rs2_E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [RA_W-1:0] rd_E,
    input  logic            MemRead_E,
    input  logic [RA_W-1:0] rd_M,
    input  logic            RegWrite_M,
    input  logic            MemRead_M,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [RA_W-1:0] rd_W,
    input  logic            RegWrite_W,
    input  logic [XLEN-1:0] write_back_result,
    output logic [XLEN-1:0] SrcA_E,
    output logic [XLEN-1:0] SrcB_E,
    output logic [1:0]      ForwardA,
    output logic [1:0]      ForwardB,
    output logic            Stall_F,
    output logic            Stall_D,
    output logic            Flush_E
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;
    localparam logic [1:0] CNT_INIT = 2'(LOAD_BUBBLES - 1);
    localparam logic       X_EN     = (RF_WRITE_THROUGH == 0);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_M  = 2'b10;
    localparam logic [1:0] SEL_W  = 2'b01;
    localparam logic [1:0] SEL_X  = 2'b11;

    logic [0:0]      r_state;
    logic [1:0]      r_cnt;
    logic            r_x_valid;
    logic [RA_W-1:0] r_x_rd;
    logic [XLEN-1:0] r_x_data;

    logic w_a_m, w_a_w, w_a_x;
    logic w_b_m, w_b_w, w_b_x;
    logic w_hz;
    logic w_stall;

    // A load's ALUResult_M is an address, not the loaded value, so MEM never forwards for loads.
    assign w_a_m = (rs1_E != '0) & RegWrite_M & ~MemRead_M & (rd_M == rs1_E);
    assign w_a_w = (rs1_E != '0) & RegWrite_W & (rd_W == rs1_E);
    assign w_a_x = (rs1_E != '0) & X_EN & r_x_valid & (r_x_rd == rs1_E);
    assign w_b_m = (rs2_E != '0) & RegWrite_M & ~MemRead_M & (rd_M == rs2_E);
    assign w_b_w = (rs2_E != '0) & RegWrite_W & (rd_W == rs2_E);
    assign w_b_x = (rs2_E != '0) & X_EN & r_x_valid & (r_x_rd == rs2_E);

    always_comb begin
        ForwardA = SEL_RF;
        SrcA_E   = RD1_E;
        if (w_a_m) begin
            ForwardA = SEL_M;
            SrcA_E   = ALUResult_M;
        end else if (w_a_w) begin
            ForwardA = SEL_W;
            SrcA_E   = write_back_result;
        end else if (w_a_x) begin
            ForwardA = SEL_X;
            SrcA_E   = r_x_data;
        end
    end

    always_comb begin
        ForwardB = SEL_RF;
        SrcB_E   = RD2_E;
        if (w_b_m) begin
            ForwardB = SEL_M;
            SrcB_E   = ALUResult_M;
        end else if (w_b_w) begin
            ForwardB = SEL_W;
            SrcB_E   = write_back_result;
        end else if (w_b_x) begin
            ForwardB = SEL_X;
            SrcB_E   = r_x_data;
        end
    end

    // Retired copy lives exactly one cycle after WB, independent of stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x_valid <= 1'b0;
            r_x_rd    <= '0;
            r_x_data  <= '0;
        end else if (RegWrite_W && (rd_W != '0)) begin
            r_x_valid <= 1'b1;
            r_x_rd    <= rd_W;
            r_x_data  <= write_back_result;
        end else begin
            r_x_valid <= 1'b0;
        end
    end

    assign w_hz = MemRead_E & (rd_E != '0) & ((rd_E == rs1_D) | (rd_E == rs2_D));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_hz && (LOAD_BUBBLES > 1)) begin
                        r_state <= ST_HOLD;
                        r_cnt   <= CNT_INIT;
                    end
                end
                ST_HOLD: begin
                    r_cnt <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // In HOLD the EX slot already carries a bubble, so a fresh hazard there adds nothing.
    assign w_stall = rst ? 1'b0 : ((r_state == ST_HOLD) | w_hz);
    assign Stall_F = w_stall;
    assign Stall_D = w_stall;
    assign Flush_E = w_stall;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: default, 3-bubble and write-through instances share stimulus.
module tb_fwd_hazard_unit;

    localparam int XLEN = 32;
    localparam int RA_W = 5;
    localparam logic [XLEN-1:0] RD1_DEF = 32'hAAAA_0001;
    localparam logic [XLEN-1:0] RD2_DEF = 32'hBBBB_0002;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, rst_lb3;
    logic [RA_W-1:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic [XLEN-1:0] RD1_E, RD2_E, ALUResult_M, write_back_result;
    logic            MemRead_E, RegWrite_M, MemRead_M, RegWrite_W;

    logic [XLEN-1:0] srca0, srcb0, srca_wt, srcb_wt, srca_lb3, srcb_lb3;
    logic [1:0]      fa0, fb0, fa_wt, fb_wt, fa_lb3, fb_lb3;
    logic            sf0, sd0, fe0, sf_wt, sd_wt, fe_wt, sf_lb3, sd_lb3, fe_lb3;

    fwd_hazard_unit u_dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .rd_E(rd_E), .MemRead_E(MemRead_E),
        .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .ALUResult_M(ALUResult_M),
        .rd_W(rd_W), .RegWrite_W(RegWrite_W), .write_back_result(write_back_result),
        .SrcA_E(srca0), .SrcB_E(srcb0), .ForwardA(fa0), .ForwardB(fb0),
        .Stall_F(sf0), .Stall_D(sd0), .Flush_E(fe0)
    );

    fwd_hazard_unit #(.LOAD_BUBBLES(3)) u_dut_lb3 (
        .clk(clk), .rst(rst_lb3),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .rd_E(rd_E), .MemRead_E(MemRead_E),
        .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .ALUResult_M(ALUResult_M),
        .rd_W(rd_W), .RegWrite_W(RegWrite_W), .write_back_result(write_back_result),
        .SrcA_E(srca_lb3), .SrcB_E(srcb_lb3), .ForwardA(fa_lb3), .ForwardB(fb_lb3),
        .Stall_F(sf_lb3), .Stall_D(sd_lb3), .Flush_E(fe_lb3)
    );

    fwd_hazard_unit #(.RF_WRITE_THROUGH(1)) u_dut_wt (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .rd_E(rd_E), .MemRead_E(MemRead_E),
        .rd_M(rd_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M), .ALUResult_M(ALUResult_M),
        .rd_W(rd_W), .RegWrite_W(RegWrite_W), .write_back_result(write_back_result),
        .SrcA_E(srca_wt), .SrcB_E(srcb_wt), .ForwardA(fa_wt), .ForwardB(fb_wt),
        .Stall_F(sf_wt), .Stall_D(sd_wt), .Flush_E(fe_wt)
    );

    typedef enum int {S_SRCA, S_SRCB, S_FWDA, S_FWDB, S_STALL,
                      S_SRCA_WT, S_FWDA_WT, S_STALL_LB3} sig_e;
    typedef struct {
        string           tag;
        sig_e            sig;
        logic [XLEN-1:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check_val(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN-1:0] observe(input sig_e s);
        case (s)
            S_SRCA:      return srca0;
            S_SRCB:      return srcb0;
            S_FWDA:      return 32'(fa0);
            S_FWDB:      return 32'(fb0);
            S_STALL:     return 32'({sf0, sd0, fe0});
            S_SRCA_WT:   return srca_wt;
            S_FWDA_WT:   return 32'(fa_wt);
            S_STALL_LB3: return 32'({sf_lb3, sd_lb3, fe_lb3});
            default:     return 'x;
        endcase
    endfunction

    task automatic expect_val(input string tag, input sig_e sig, input logic [XLEN-1:0] exp);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    // Sample mid-cycle, drain the scoreboard, then return just after the next rising edge.
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check_val(e.tag, observe(e.sig), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rs1_D = '0; rs2_D = '0; rs1_E = '0; rs2_E = '0; rd_E = '0; rd_M = '0; rd_W = '0;
        RD1_E = RD1_DEF; RD2_E = RD2_DEF; ALUResult_M = '0; write_back_result = '0;
        MemRead_E = 1'b0; RegWrite_M = 1'b0; MemRead_M = 1'b0; RegWrite_W = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        rst_lb3 = 1'b1;
        @(posedge clk);
        #1;

        // Reset cycle: stalls forced low even with a live hazard, forwarding still live.
        MemRead_E = 1'b1; rd_E = 5'd3; rs2_D = 5'd3;
        rs1_E = 5'd5; rd_M = 5'd5; RegWrite_M = 1'b1; ALUResult_M = 32'h11;
        expect_val("rst_stall", S_STALL, 32'd0);
        expect_val("rst_stall_lb3", S_STALL_LB3, 32'd0);
        expect_val("rst_fwda", S_FWDA, 32'd2);
        expect_val("rst_srca", S_SRCA, 32'h11);
        step();
        rst = 1'b0;
        rst_lb3 = 1'b0;

        idle_inputs();
        expect_val("post_rst_fwda", S_FWDA, 32'd0);
        expect_val("post_rst_srca", S_SRCA, RD1_DEF);
        expect_val("post_rst_stall", S_STALL, 32'd0);
        step();

        // RAW distance 1 from MEM
        idle_inputs();
        rd_M = 5'd5; RegWrite_M = 1'b1; rs1_E = 5'd5; ALUResult_M = 32'h11;
        expect_val("raw1_fwda", S_FWDA, 32'd2);
        expect_val("raw1_srca", S_SRCA, 32'h11);
        expect_val("raw1_stall", S_STALL, 32'd0);
        step();

        // Double hit: M wins, unless M is a load
        idle_inputs();
        rd_M = 5'd7; rd_W = 5'd7; RegWrite_M = 1'b1; RegWrite_W = 1'b1;
        rs2_E = 5'd7; ALUResult_M = 32'hA; write_back_result = 32'hB;
        expect_val("dbl_fwdb", S_FWDB, 32'd2);
        expect_val("dbl_srcb", S_SRCB, 32'hA);
        step();
        MemRead_M = 1'b1;
        expect_val("dbl_ld_fwdb", S_FWDB, 32'd1);
        expect_val("dbl_ld_srcb", S_SRCB, 32'hB);
        step();

        // Independent selection per operand
        idle_inputs();
        rs1_E = 5'd5; rd_M = 5'd5; RegWrite_M = 1'b1; ALUResult_M = 32'h21;
        rs2_E = 5'd6; rd_W = 5'd6; RegWrite_W = 1'b1; write_back_result = 32'h66;
        expect_val("indep_fwda", S_FWDA, 32'd2);
        expect_val("indep_srca", S_SRCA, 32'h21);
        expect_val("indep_fwdb", S_FWDB, 32'd1);
        expect_val("indep_srcb", S_SRCB, 32'h66);
        step();

        // r0 never forwards
        idle_inputs();
        rs1_E = 5'd0; rd_M = 5'd0; RegWrite_M = 1'b1; rd_W = 5'd0; RegWrite_W = 1'b1;
        RD1_E = 32'hCAFE_0000; ALUResult_M = 32'h1; write_back_result = 32'h2;
        expect_val("x0_fwda", S_FWDA, 32'd0);
        expect_val("x0_srca", S_SRCA, 32'hCAFE_0000);
        step();

        // Retired bypass: WB r9, then X for exactly one cycle
        idle_inputs();
        RegWrite_W = 1'b1; rd_W = 5'd9; write_back_result = 32'h55; rs1_E = 5'd9;
        expect_val("ret_w_fwda", S_FWDA, 32'd1);
        expect_val("ret_w_srca", S_SRCA, 32'h55);
        step();
        idle_inputs();
        rs1_E = 5'd9;
        expect_val("ret_x_fwda", S_FWDA, 32'd3);
        expect_val("ret_x_srca", S_SRCA, 32'h55);
        expect_val("ret_wt_fwda", S_FWDA_WT, 32'd0);
        expect_val("ret_wt_srca", S_SRCA_WT, RD1_DEF);
        step();
        idle_inputs();
        rs1_E = 5'd9;
        expect_val("ret_gone_fwda", S_FWDA, 32'd0);
        expect_val("ret_gone_srca", S_SRCA, RD1_DEF);
        step();

        // W beats X; a load in MEM falls through to X
        idle_inputs();
        RegWrite_W = 1'b1; rd_W = 5'd9; write_back_result = 32'h55;
        step();
        rs1_E = 5'd9; rd_M = 5'd9; RegWrite_M = 1'b1; MemRead_M = 1'b1; ALUResult_M = 32'h1000;
        write_back_result = 32'h99;
        expect_val("w_over_x_fwda", S_FWDA, 32'd1);
        expect_val("w_over_x_srca", S_SRCA, 32'h99);
        step();
        RegWrite_W = 1'b0;
        expect_val("ldm_x_fwda", S_FWDA, 32'd3);
        expect_val("ldm_x_srca", S_SRCA, 32'h99);
        expect_val("ldm_wt_fwda", S_FWDA_WT, 32'd0);
        step();

        // Load-use via rs2_D: one bubble on default, three on the LB3 instance
        idle_inputs();
        MemRead_E = 1'b1; rd_E = 5'd3; rs2_D = 5'd3;
        expect_val("lu1_stall_c1", S_STALL, 32'd7);
        expect_val("lu3_stall_c1", S_STALL_LB3, 32'd7);
        step();
        idle_inputs();
        rs2_D = 5'd3; rs2_E = 5'd3; rd_W = 5'd3; RegWrite_W = 1'b1; write_back_result = 32'h77;
        expect_val("lu1_stall_c2", S_STALL, 32'd0);
        expect_val("lu1_fwdb", S_FWDB, 32'd1);
        expect_val("lu1_srcb", S_SRCB, 32'h77);
        expect_val("lu3_stall_c2", S_STALL_LB3, 32'd7);
        step();
        idle_inputs();
        expect_val("lu3_stall_c3", S_STALL_LB3, 32'd7);
        expect_val("lu1_stall_c3", S_STALL, 32'd0);
        step();
        expect_val("lu3_stall_c4", S_STALL_LB3, 32'd0);
        step();

        // rd_E==0 load never stalls
        MemRead_E = 1'b1; rd_E = 5'd0; rs1_D = 5'd0;
        expect_val("lu_r0_stall", S_STALL, 32'd0);
        expect_val("lu_r0_stall_lb3", S_STALL_LB3, 32'd0);
        step();

        // LB3 with reset in the second stall cycle
        idle_inputs();
        MemRead_E = 1'b1; rd_E = 5'd8; rs1_D = 5'd8;
        expect_val("lu3r_stall_c1", S_STALL_LB3, 32'd7);
        expect_val("lu1r_stall_c1", S_STALL, 32'd7);
        step();
        idle_inputs();
        rst_lb3 = 1'b1;
        expect_val("lu3r_stall_rst", S_STALL_LB3, 32'd0);
        step();
        rst_lb3 = 1'b0;
        expect_val("lu3r_stall_after", S_STALL_LB3, 32'd0);
        step();
        expect_val("lu3r_stall_after2", S_STALL_LB3, 32'd0);
        step();

        // Fresh hazard after reset still gives exactly three bubbles
        MemRead_E = 1'b1; rd_E = 5'd8; rs2_D = 5'd8;
        expect_val("lu3n_stall_c1", S_STALL_LB3, 32'd7);
        step();
        idle_inputs();
        expect_val("lu3n_stall_c2", S_STALL_LB3, 32'd7);
        step();
        expect_val("lu3n_stall_c3", S_STALL_LB3, 32'd7);
        step();
        expect_val("lu3n_stall_c4", S_STALL_LB3, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
